// File: rtl/pipe_control_unit.sv
// RV32I pipelined control: decodes opcode in ID, carries controls through EX/MEM/WB, EBREAK halt/drain.
// ex_* one edge after accept, mem_* two, wb_* three; stall/flush/non-RUN insert bubbles, pc_en gates fetch.
module pipe_control_unit #(
  parameter int ALUOP_W         = 2,
  parameter int CNT_W           = 32,
  parameter int HALT_ON_ILLEGAL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [4:0]         opcode,
  input  logic               inst20,
  input  logic               stall,
  input  logic               flush,
  output logic               pc_en,
  output logic               ex_valid,
  output logic               ex_branch,
  output logic               ex_alusrc,
  output logic               ex_jalr,
  output logic               ex_jal,
  output logic               ex_auipc,
  output logic               ex_lui,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               mem_valid,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_valid,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic               illegal,
  output logic               halted,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam logic [4:0] OP_RTYPE  = 5'b01100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_IALU   = 5'b00100;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  localparam bit HALT_ILL = (HALT_ON_ILLEGAL != 0);

  typedef struct packed {
    logic               branch;
    logic               alusrc;
    logic               jalr;
    logic               jal;
    logic               auipc;
    logic               lui;
    logic [ALUOP_W-1:0] aluop;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               memtoreg;
  } ctrl_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  state_t state, state_nx;
  ctrl_t  dec, ex_ctl;
  logic   dec_legal, is_system, accept, take_ebreak;
  logic   mem_regwrite, mem_memtoreg;

  always_comb begin
    dec       = '0;
    dec_legal = 1'b1;
    case (opcode)
      OP_RTYPE:  begin dec.aluop = ALUOP_W'(2'b10); dec.regwrite = 1'b1; end
      OP_LOAD:   begin dec.memread = 1'b1; dec.memtoreg = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
      OP_STORE:  begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; end
      OP_BRANCH: begin dec.branch = 1'b1; dec.aluop = ALUOP_W'(2'b01); end
      OP_AUIPC:  begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.auipc = 1'b1; end
      OP_LUI:    begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.lui = 1'b1; end
      OP_JAL:    begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.jalr = 1'b1; dec.jal = 1'b1; end
      OP_JALR:   begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.jalr = 1'b1; end
      OP_IALU:   begin dec.aluop = ALUOP_W'(2'b11); dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
      OP_SYSTEM: dec = '0;
      default:   dec_legal = 1'b0;
    endcase
  end

  assign is_system   = (opcode == OP_SYSTEM);
  assign accept      = id_valid && (state == S_RUN) && !stall && !flush;
  assign take_ebreak = accept && is_system && inst20;

  // SYSTEM (ECALL/EBREAK) and illegal opcodes are accepted but enter EX as bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctl   <= '0;
      ex_valid <= 1'b0;
    end else if (accept && dec_legal && !is_system) begin
      ex_ctl   <= dec;
      ex_valid <= 1'b1;
    end else begin
      ex_ctl   <= '0;
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid    <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
    end else if (flush) begin
      mem_valid    <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
    end else begin
      mem_valid    <= ex_valid;
      mem_read     <= ex_ctl.memread;
      mem_write    <= ex_ctl.memwrite;
      mem_regwrite <= ex_ctl.regwrite;
      mem_memtoreg <= ex_ctl.memtoreg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_memtoreg <= 1'b0;
      retire_cnt  <= '0;
      illegal     <= 1'b0;
    end else begin
      wb_valid    <= mem_valid;
      wb_regwrite <= mem_regwrite;
      wb_memtoreg <= mem_memtoreg;
      illegal     <= accept && !dec_legal;
      if (wb_valid) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign ex_branch = ex_ctl.branch;
  assign ex_alusrc = ex_ctl.alusrc;
  assign ex_jalr   = ex_ctl.jalr;
  assign ex_jal    = ex_ctl.jal;
  assign ex_auipc  = ex_ctl.auipc;
  assign ex_lui    = ex_ctl.lui;
  assign ex_aluop  = ex_ctl.aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:   if (take_ebreak || (HALT_ILL && accept && !dec_legal)) state_nx = S_DRAIN;
      S_DRAIN: if (!(ex_valid || mem_valid || wb_valid)) state_nx = S_HALT;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RUN;
    endcase
  end

  always_comb begin
    pc_en  = 1'b0;
    halted = 1'b0;
    case (state)
      S_RUN:   pc_en = !stall;
      S_HALT:  halted = 1'b1;
      default: pc_en = 1'b0;
    endcase
  end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Pipelined successor to the single-cycle RV32I main decoder.
- Decodes opcode[6:2] in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers, with a valid bit per stage.
- Applies stall bubbles and flushes, runs an EBREAK halt/drain state machine, and counts retired instructions.
- Sits between the IF/ID register and the datapath stage muxes.

Parameters:
- ALUOP_W, 2, width of the ALUOp field.
- CNT_W, 32, width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 0, 1 = an unknown opcode halts like EBREAK; 0 = it becomes a bubble.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- opcode  in  5  instruction bits [6:2].
- inst20  in  1  instruction bit 20 (EBREAK vs ECALL).
- stall  in  1  load-use hazard: bubble into ID/EX.
- flush  in  1  taken branch/jump: kill ID/EX and EX/MEM contents.
- pc_en  out  1  PC / IF/ID write enable.
- ex_valid, ex_branch, ex_alusrc, ex_jalr, ex_jal, ex_auipc, ex_lui  out  1 each  EX-stage controls.
- ex_aluop  out  ALUOP_W  EX-stage ALU operation.
- mem_valid, mem_read, mem_write  out  1 each  MEM-stage controls.
- wb_valid, wb_regwrite, wb_memtoreg  out  1 each  WB-stage controls.
- illegal  out  1  one-cycle registered pulse for an undecodable opcode.
- halted  out  1  pipeline has drained after EBREAK.
- retire_cnt  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (rst_n=0, asynchronous): every stage register and valid bit = 0, illegal=0, halted=0, retire_cnt=0, FSM=RUN. pc_en=1 is combinational from RUN.
- Decode table (combinational, bits given as br/MRd/M2R/ALUOp/MWr/ASrc/RWr/jalr/auipc/jal/lui):
  - 01100 R-type: 0/0/0/10/0/0/1/0/0/0/0
  - 00000 load: 0/1/1/00/0/1/1/0/0/0/0
  - 01000 store: 0/0/0/00/1/1/0/0/0/0/0
  - 11000 branch: 1/0/0/01/0/0/0/0/0/0/0
  - 00101 auipc: RWr=1, ASrc=1, auipc=1, all others 0
  - 01101 lui: RWr=1, ASrc=1, lui=1, all others 0
  - 11011 jal: RWr=1, ASrc=1, jalr=1, jal=1, all others 0
  - 11001 jalr: RWr=1, ASrc=1, jalr=1, all others 0
  - 00100 I-ALU: ALUOp=11, ASrc=1, RWr=1, all others 0
  - 11100 SYSTEM: all controls 0 (ECALL is a nop).
  - ALUOp is zero-extended to ALUOP_W.
- Accept condition: accept = id_valid & FSM==RUN & !stall & !flush.
- ID/EX load: on accept, ID/EX loads the decoded bundle and ex_valid=1. Otherwise it loads all-zero and ex_valid=0.
  - EBREAK never enters as valid.
  - An illegal opcode never enters as valid.
- EX/MEM: loads the MEM/WB fields of ID/EX each cycle; flush forces a zero bundle with mem_valid=0.
- MEM/WB: always loads from EX/MEM; flush does not affect it.
- Latency: an instruction accepted at edge N shows ex_* after N, mem_* after N+1, wb_* after N+2. retire_cnt increments at edge N+3 if wb_valid=1.
- retire_cnt: increments by 1 on each edge where wb_valid=1, wraps modulo 2^CNT_W, and keeps counting during DRAIN.
- illegal: registered; set for one cycle after an edge where id_valid & RUN & !stall & !flush and the opcode is not in the table.
- FSM RUN: pc_en = !stall.
  - Go to DRAIN on an edge with id_valid & !stall & !flush & opcode=11100 & inst20=1.
  - Also go to DRAIN on an illegal opcode when HALT_ON_ILLEGAL=1.
- FSM DRAIN: pc_en=0; no new instructions are accepted; older instructions continue to advance.
  - Go to HALTED on the first edge where ex_valid|mem_valid|wb_valid = 0.
- FSM HALTED: pc_en=0, halted=1. Sticky; only reset leaves this state.
- Priority cases:
  - flush in the same cycle as an EBREAK decode: flush wins, FSM stays in RUN.
  - stall together with EBREAK: the EBREAK is deferred until stall=0.
  - stall together with flush: flush semantics apply.
  - flush during DRAIN: clears ID/EX and EX/MEM as usual, which can shorten the drain.
- Reset in any state, including mid-DRAIN: returns to RUN with cleared pipeline registers.

Test Plan:
- Reset, then R-type (01100) with id_valid=1 at edge 1 -> after edge 1: ex_valid=1, ex_aluop=10, ex_alusrc=0; after edge 3: wb_regwrite=1; retire_cnt=1 after edge 4.
- Load (00000) then stall=1 for one cycle on the next instruction -> ID/EX holds zeros with ex_valid=0 for one cycle, pc_en=0 in the stall cycle; the load reaches WB with wb_memtoreg=1.
- Branch in EX, flush=1 for one cycle -> ex_valid and mem_valid are 0 next cycle; the older instruction in MEM still retires (retire_cnt +1, not +3).
- Add, sw, EBREAK (11100, inst20=1) -> pc_en=0 from the cycle after EBREAK; halted=1 after add and sw retire; retire_cnt=2; ECALL (inst20=0) alone only retires nothing and does not halt.
- Opcode 11111 with HALT_ON_ILLEGAL=0 -> illegal pulses one cycle, no halt. With HALT_ON_ILLEGAL=1 -> DRAIN, then halted=1.
- CNT_W=4, issue 17 back-to-back adds -> retire_cnt wraps to 1. Assert rst_n=0 mid-DRAIN -> all outputs return to reset values immediately.
